// File: rtl/register_bank_if.sv
// Bus between the MIPS datapath and its general-purpose register bank.
// Latency: none of its own; it only carries the register bank's read, write and count signals.
// Backpressure: none; every write sampled with regWrite=1 completes in one cycle.
// Ports (master = datapath, slave = register bank):
//   rdAddr1/rdAddr2 -> rdData1/rdData2 : combinational read ports (rs / rt)
//   wrAddr, wrData, regWrite           : synchronous write port (dest mux, write-back)
//   wrCount                            : committed-write counter, saturating at 16'hFFFF
interface register_bank_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
);
   logic [ADDR_W-1:0] rdAddr1;
   logic [ADDR_W-1:0] rdAddr2;
   logic [ADDR_W-1:0] wrAddr;
   logic [DATA_W-1:0] wrData;
   logic              regWrite;
   logic [DATA_W-1:0] rdData1;
   logic [DATA_W-1:0] rdData2;
   logic [15:0]       wrCount;

   modport master (
      output rdAddr1, rdAddr2, wrAddr, wrData, regWrite,
      input  rdData1, rdData2, wrCount
   );

   modport slave (
      input  rdAddr1, rdAddr2, wrAddr, wrData, regWrite,
      output rdData1, rdData2, wrCount
   );
endinterface

// File: rtl/register_bank.sv
// Register bank of the single-cycle MIPS datapath: 2 combinational read ports, 1 write port, r0 == 0.
// Latency: reads 0 cycles, writes visible 1 cycle later (same cycle when REG_BYPASS_EN is defined).
// Backpressure: none; every write sampled with regWrite=1 completes on that edge.
// Ports: clk (rising-edge writes), rst_n (async active-low, clears all registers and wrCount),
//        bus (register_bank_if.slave: rdAddr1/2 -> rdData1/2, wrAddr/wrData/regWrite, wrCount).
// Optional feature macro: REG_BYPASS_EN -- same-cycle write-through from wrData to a read port
//        whose address matches a live write; undefined gives old-contents-until-edge reads.
module register_bank #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5
) (
   input logic            clk,
   input logic            rst_n,
   register_bank_if.slave bus
);
   localparam int DEPTH = 2 ** ADDR_W;

   // Entry 0 is never written, so it stays at its reset value and synthesis trims it away.
   logic [DATA_W-1:0] regs [0:DEPTH-1];
   logic [15:0]       wrCountQ;
   logic              wrEn;
   logic [DATA_W-1:0] rdData1Int;
   logic [DATA_W-1:0] rdData2Int;

   // A write to r0 is dropped completely: no storage update and no count.
   assign wrEn = bus.regWrite && (bus.wrAddr != '0);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            regs[i] <= '0;
         end
      end else if (wrEn) begin
         regs[bus.wrAddr] <= bus.wrData;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         wrCountQ <= '0;
      end else if (wrEn && (wrCountQ != 16'hFFFF)) begin
         wrCountQ <= wrCountQ + 16'd1;
      end
   end

`ifdef REG_BYPASS_EN
   // Forwarding is gated with rst_n so the ports still read 0 while reset is held,
   // even if a write is being presented at the same time.
   logic bypassLive;
   assign bypassLive = rst_n && wrEn;

   always_comb begin
      rdData1Int = '0;
      if (bus.rdAddr1 != '0) begin
         rdData1Int = regs[bus.rdAddr1];
         if (bypassLive && (bus.rdAddr1 == bus.wrAddr)) begin
            rdData1Int = bus.wrData;
         end
      end
   end

   always_comb begin
      rdData2Int = '0;
      if (bus.rdAddr2 != '0) begin
         rdData2Int = regs[bus.rdAddr2];
         if (bypassLive && (bus.rdAddr2 == bus.wrAddr)) begin
            rdData2Int = bus.wrData;
         end
      end
   end
`else
   // Without forwarding a port shows the stored value until the write edge.
   always_comb begin
      rdData1Int = '0;
      if (bus.rdAddr1 != '0) begin
         rdData1Int = regs[bus.rdAddr1];
      end
   end

   always_comb begin
      rdData2Int = '0;
      if (bus.rdAddr2 != '0) begin
         rdData2Int = regs[bus.rdAddr2];
      end
   end
`endif

   assign bus.rdData1 = rdData1Int;
   assign bus.rdData2 = rdData2Int;
   assign bus.wrCount = wrCountQ;
endmodule
